// File: rtl/requant_pkg.sv
// rtl/requant_pkg.sv - shared state type, index width helper and requantiser for the tile buffer
package requant_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DRAIN} state_t;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Evaluated at 64 bits so neither the rounding add nor the shift can overflow.
  function automatic logic [31:0] sat_requant(input logic signed [63:0] data, input int shift,
                                              input bit round, input int ow);
    logic signed [63:0] t;
    logic signed [63:0] q;
    logic signed [63:0] maxv;
    t = data + (round ? (64'sd1 <<< (shift - 1)) : 64'sd0);
    q = t >>> shift;
    maxv = (64'sd1 <<< ow) - 64'sd1;
    if (q < 0) return 32'd0;
    else if (q > maxv) return maxv[31:0];
    else return q[31:0];
  endfunction

  function automatic logic sat_clamps(input logic signed [63:0] data, input int shift,
                                      input bit round, input int ow);
    logic signed [63:0] t;
    logic signed [63:0] q;
    t = data + (round ? (64'sd1 <<< (shift - 1)) : 64'sd0);
    q = t >>> shift;
    return (q < 0) || (q > ((64'sd1 <<< ow) - 64'sd1));
  endfunction

endpackage

// File: rtl/rc_index_counter.sv
// rtl/rc_index_counter.sv - row/column tile index counter, row-major or column-major walk
module rc_index_counter import requant_pkg::*; #(
  parameter int ROWS = 8,
  parameter int COLS = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     clear,
  input  logic                     col_major,
  output logic [idx_w(ROWS)-1:0]   r,
  output logic [idx_w(COLS)-1:0]   c,
  output logic                     last
);
  localparam int RW = idx_w(ROWS);
  localparam int CW = idx_w(COLS);
  localparam logic [RW-1:0] R_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] C_MAX = CW'(COLS - 1);

  logic r_wrap;
  logic c_wrap;

  assign r_wrap = (r == R_MAX);
  assign c_wrap = (c == C_MAX);
  assign last   = r_wrap && c_wrap;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r <= '0;
      c <= '0;
    end else if (clear) begin
      r <= '0;
      c <= '0;
    end else if (enable) begin
      if (!col_major) begin
        c <= c_wrap ? '0 : c + CW'(1);
        if (c_wrap) r <= r_wrap ? '0 : r + RW'(1);
      end else begin
        r <= r_wrap ? '0 : r + RW'(1);
        if (r_wrap) c <= c_wrap ? '0 : c + CW'(1);
      end
    end
  end

endmodule

// File: rtl/requant_block_buffer.sv
// rtl/requant_block_buffer.sv - requantising ROWS x COLS tile store with row-major or transposed drain
module requant_block_buffer import requant_pkg::*; #(
  parameter int DW    = 16,
  parameter int OW    = 8,
  parameter int SHIFT = 8,
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int ROUND = 0
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              start,
  input  logic                              transpose,
  input  logic                              in_valid,
  input  logic [DW-1:0]                     in_data,
  output logic                              in_ready,
  output logic                              out_valid,
  output logic [OW-1:0]                     out_data,
  input  logic                              out_ready,
  output logic                              out_last,
  output logic                              busy,
  output logic                              done,
  output logic [idx_w(ROWS*COLS+1)-1:0]     sat_count
);
  localparam int RW = idx_w(ROWS);
  localparam int CW = idx_w(COLS);
  localparam int SW = idx_w(ROWS * COLS + 1);

  state_t state, state_next;
  logic   xpose;
  logic   arm;
  logic   wr_fire, rd_fire, clamped;
  logic [RW-1:0] wr_r, rd_r;
  logic [CW-1:0] wr_c, rd_c;
  logic   wr_last, rd_last;
  logic signed [63:0] sample_ext;
  logic [OW-1:0] tile [ROWS][COLS];

  assign sample_ext = 64'(signed'(in_data));
  assign clamped    = sat_clamps(sample_ext, SHIFT, ROUND != 0, OW);
  assign wr_fire    = in_valid && in_ready;
  assign rd_fire    = out_valid && out_ready;
  assign out_last   = out_valid && rd_last;
  assign out_data   = out_valid ? tile[rd_r][rd_c] : '0;

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    arm        = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          arm        = 1'b1;
          state_next = ST_FILL;
        end
      end
      ST_FILL: begin
        in_ready = 1'b1;
        if (in_valid && wr_last) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && rd_last) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      xpose     <= 1'b0;
      sat_count <= '0;
      done      <= 1'b0;
    end else begin
      state <= state_next;
      done  <= rd_fire && rd_last;
      if (arm) begin
        xpose     <= transpose;
        sat_count <= '0;
      end else if (wr_fire && clamped) begin
        sat_count <= sat_count + SW'(1);
      end
    end
  end

  // Tile storage is deliberately left out of reset; only the indices restart.
  always_ff @(posedge clock) begin
    if (wr_fire) tile[wr_r][wr_c] <= OW'(sat_requant(sample_ext, SHIFT, ROUND != 0, OW));
  end

  rc_index_counter #(.ROWS(ROWS), .COLS(COLS)) u_wr_idx (
    .clock(clock), .reset_n(reset_n), .enable(wr_fire), .clear(arm), .col_major(1'b0),
    .r(wr_r), .c(wr_c), .last(wr_last)
  );

  rc_index_counter #(.ROWS(ROWS), .COLS(COLS)) u_rd_idx (
    .clock(clock), .reset_n(reset_n), .enable(rd_fire), .clear(arm), .col_major(xpose),
    .r(rd_r), .c(rd_c), .last(rd_last)
  );

endmodule
